// File: rtl/apb_master.sv
// APB requester: converts a single-beat command into an APB SETUP/ACCESS transfer.
// A watchdog aborts an ACCESS phase that waits too long for pready.
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam bit              WD_EN   = (TIMEOUT != 0);
    // With the watchdog disabled this value is never compared.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             wd_hit_s;

    assign cmd_ready = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign wd_hit_s  = WD_EN && (cnt_r == WD_LAST);

    // Transfer sequencer, APB drive and response registers.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= {ADDR_W{1'b0}};
            pwdata      <= {DATA_W{1'b0}};
            rsp_valid   <= 1'b0;
            rsp_rdata   <= {DATA_W{1'b0}};
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite  <= cmd_write;
                        paddr   <= cmd_addr;
                        pwdata  <= cmd_wdata;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= SETUP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state_r <= ACCESS;
                end
                ACCESS: begin
                    // pready in the final watchdog cycle still completes normally.
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= pwrite ? {DATA_W{1'b0}} : prdata;
                        state_r     <= IDLE;
                    end else if (wd_hit_s) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= {DATA_W{1'b0}};
                        state_r     <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
